// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: redirect source encoding and fetch-queue entry layout.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    JAL  = 3'd1,
    BR   = 3'd2,
    JALR = 3'd3,
    IRQ  = 3'd4
  } redir_src_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inst;
    logic                    filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated at request time, filled in order by responses,
// and popped from the head once filled. Pointers carry an extra bit so 0 and FQ_DEPTH are distinct.
module fetch_queue #(
  parameter int XLEN     = 32,
  parameter int FQ_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      alloc,
  input  logic [XLEN-1:0]           alloc_pc,
  input  logic                      fill,
  input  logic [XLEN-1:0]           fill_inst,
  input  logic                      pop,
  output logic                      head_filled,
  output logic [XLEN-1:0]           head_pc,
  output logic [XLEN-1:0]           head_inst,
  output logic [$clog2(FQ_DEPTH):0] count,
  output logic [$clog2(FQ_DEPTH):0] unfilled
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]         wr_ptr_r;
  logic [AW:0]         fill_ptr_r;
  logic [AW:0]         rd_ptr_r;
  logic [XLEN-1:0]     pc_mem_r   [FQ_DEPTH];
  logic [XLEN-1:0]     inst_mem_r [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] filled_r;

  // Occupancy and head view derived from the pointers.
  always_comb begin
    count       = wr_ptr_r - rd_ptr_r;
    unfilled    = wr_ptr_r - fill_ptr_r;
    head_filled = filled_r[rd_ptr_r[AW-1:0]] & (count != {(AW+1){1'b0}});
    head_pc     = pc_mem_r[rd_ptr_r[AW-1:0]];
    head_inst   = inst_mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer and entry storage; the caller never targets one slot with two operations at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      fill_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      filled_r   <= {FQ_DEPTH{1'b0}};
      for (int i = 0; i < FQ_DEPTH; i++) begin
        pc_mem_r[i]   <= {XLEN{1'b0}};
        inst_mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      fill_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      filled_r   <= {FQ_DEPTH{1'b0}};
    end else begin
      if (alloc) begin
        pc_mem_r[wr_ptr_r[AW-1:0]]   <= alloc_pc;
        inst_mem_r[wr_ptr_r[AW-1:0]] <= {XLEN{1'b0}};
        filled_r[wr_ptr_r[AW-1:0]]   <= 1'b0;
        wr_ptr_r                     <= wr_ptr_r + PTR_ONE;
      end
      if (fill) begin
        inst_mem_r[fill_ptr_r[AW-1:0]] <= fill_inst;
        filled_r[fill_ptr_r[AW-1:0]]   <= 1'b1;
        fill_ptr_r                     <= fill_ptr_r + PTR_ONE;
      end
      if (pop) begin
        filled_r[rd_ptr_r[AW-1:0]] <= 1'b0;
        rd_ptr_r                   <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC select by redirect priority, stale-response drop counter and imem issue.
// Trap redirect with epc is built only when FETCH_IRQ_EN is defined.
module fetch_unit #(
  parameter int              XLEN     = fetch_pkg::XLEN_DEFAULT,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_IRQ_EN
  ,
  parameter logic [XLEN-1:0] IRQ_VECTOR = 32'h0000_0010
`endif
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            halt,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal_valid,
  input  logic [XLEN-1:0] jal_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_inst
`ifdef FETCH_IRQ_EN
  ,
  input  logic            irq,
  output logic [XLEN-1:0] epc
`endif
);

  import fetch_pkg::*;

  localparam int              CW      = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_L = (CW+1)'(FQ_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(2'b11);
  endfunction

  logic [XLEN-1:0] pc_r;
  logic [CW-1:0]   drop_cnt_r;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] head_pc_s;
  logic [XLEN-1:0] head_inst_s;
  logic            head_filled_s;
  logic [CW-1:0]   count_s;
  logic [CW-1:0]   unfilled_s;
  logic [CW-1:0]   inflight_s;
  logic [CW:0]     alloc_total_s;
  logic            ext_redir_s;
  logic            irq_take_s;
  logic            redirect_s;
  logic            pop_s;
  logic            req_fire_s;
  logic            rsp_drop_s;
  logic            fill_s;
  redir_src_e      src_s;

  // Handshakes, issue gating and response routing.
  always_comb begin
    ext_redir_s = jalr_valid | br_valid | jal_valid;
    dec_valid   = head_filled_s & ~ext_redir_s;
    pop_s       = dec_valid & dec_ready;
`ifdef FETCH_IRQ_EN
    irq_take_s  = irq & pop_s;
`else
    irq_take_s  = 1'b0;
`endif
    redirect_s     = ext_redir_s | irq_take_s;
    alloc_total_s  = {1'b0, count_s} + {1'b0, drop_cnt_r};
    imem_req_valid = reset & ~halt & ~redirect_s & (alloc_total_s < DEPTH_L);
    imem_req_addr  = pc_r;
    req_fire_s     = imem_req_valid & imem_req_ready;
    rsp_drop_s     = imem_rsp_valid & (drop_cnt_r != {CW{1'b0}});
    fill_s         = imem_rsp_valid & (drop_cnt_r == {CW{1'b0}}) & ~redirect_s
                     & (unfilled_s != {CW{1'b0}});
    dec_pc         = dec_valid ? head_pc_s : {XLEN{1'b0}};
    dec_inst       = dec_valid ? head_inst_s : {XLEN{1'b0}};
  end

  // Requests still owed by imem after a redirect edge; a response landing now is not owed.
  always_comb begin
    inflight_s = drop_cnt_r + unfilled_s;
    if (imem_rsp_valid && (inflight_s != {CW{1'b0}})) begin
      inflight_s = inflight_s - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      inflight_s = inflight_s;
    end
  end

  // Redirect source priority.
  always_comb begin
    src_s = SEQ;
    if (jalr_valid) begin
      src_s = JALR;
    end else if (br_valid) begin
      src_s = BR;
    end else if (jal_valid) begin
      src_s = JAL;
    end else if (irq_take_s) begin
      src_s = IRQ;
    end else begin
      src_s = SEQ;
    end
  end

  // Redirect target for the selected source.
  always_comb begin
    target_s = pc_r;
    case (src_s)
      JALR:    target_s = word_align(jalr_target);
      BR:      target_s = word_align(br_target);
      JAL:     target_s = word_align(jal_target);
`ifdef FETCH_IRQ_EN
      IRQ:     target_s = word_align(IRQ_VECTOR);
`endif
      default: target_s = pc_r;
    endcase
  end

  // Fetch PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else if (redirect_s) begin
      pc_r <= target_s;
    end else if (req_fire_s) begin
      pc_r <= pc_r + PC_STEP;
    end
  end

  // Count of responses still to be discarded after redirects.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= {CW{1'b0}};
    end else if (redirect_s) begin
      drop_cnt_r <= inflight_s;
    end else if (rsp_drop_s) begin
      drop_cnt_r <= drop_cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end
  end

`ifdef FETCH_IRQ_EN
  logic [XLEN-1:0] epc_r;

  // Return PC of the instruction handed to decode as the trap is taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      epc_r <= {XLEN{1'b0}};
    end else if (irq_take_s) begin
      epc_r <= head_pc_s + PC_STEP;
    end
  end

  assign epc = epc_r;
`endif

  fetch_queue #(
    .XLEN     (XLEN),
    .FQ_DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clock       (clock),
    .reset       (reset),
    .flush       (redirect_s),
    .alloc       (req_fire_s),
    .alloc_pc    (pc_r),
    .fill        (fill_s),
    .fill_inst   (imem_rsp_data),
    .pop         (pop_s),
    .head_filled (head_filled_s),
    .head_pc     (head_pc_s),
    .head_inst   (head_inst_s),
    .count       (count_s),
    .unfilled    (unfilled_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked against a queue-level model.
// Trap checks are compiled in when FETCH_IRQ_EN is defined.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] IRQV  = 32'h0000_0010;

  logic        clock = 1'b0;
  logic        reset;
  logic        halt;
  logic        jalr_valid, br_valid, jal_valid;
  logic [31:0] jalr_target, br_target, jal_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_inst;
`ifdef FETCH_IRQ_EN
  logic        irq;
  logic [31:0] epc;
`endif

  always #5 clock = ~clock;

  fetch_unit #(.XLEN(32), .FQ_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .halt(halt),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .br_valid(br_valid), .br_target(br_target),
    .jal_valid(jal_valid), .jal_target(jal_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_inst(dec_inst)
`ifdef FETCH_IRQ_EN
    , .irq(irq), .epc(epc)
`endif
  );

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat_lo = 1;
  int lat_hi = 1;

  // reference model: architectural PC, queue of fetched entries, responses owed to dropped requests
  fq_entry_t   m_q[$];
  int          m_drop = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_epc = 32'h0;
  // imem environment: outstanding request addresses and the cycle each response becomes due
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_1E77;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete(); m_drop = 0; m_pc = 32'h0; m_epc = 32'h0;
    pend_addr.delete(); pend_due.delete();
  endtask

  // one clock cycle: present response, check at negedge, advance model and imem environment
  task automatic step();
    logic        ext, dv, take, redir, rv, rsp, fire;
    logic [31:0] tgt, exp_pc, exp_inst;
    int          owed;
    fq_entry_t   e;
    rsp = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pend_addr[0]) : 32'h0;
    @(negedge clock);
    ext  = jalr_valid | br_valid | jal_valid;
    dv   = !ext && (m_q.size() > 0) && m_q[0].filled;
    take = 1'b0;
`ifdef FETCH_IRQ_EN
    take = irq && !ext && dv && dec_ready;
`endif
    redir    = ext || take;
    rv       = !halt && !redir && ((m_q.size() + m_drop) < DEPTH);
    exp_pc   = dv ? m_q[0].pc : 32'h0;
    exp_inst = dv ? m_q[0].inst : 32'h0;
    check("req_valid", {31'h0, imem_req_valid}, {31'h0, rv});
    check("req_addr", imem_req_addr, m_pc);
    check("dec_valid", {31'h0, dec_valid}, {31'h0, dv});
    check("dec_pc", dec_pc, exp_pc);
    check("dec_inst", dec_inst, exp_inst);
`ifdef FETCH_IRQ_EN
    check("epc", epc, m_epc);
`endif
    owed = pend_addr.size() - (rsp ? 1 : 0);
    fire = imem_req_valid && imem_req_ready;
    if (rsp) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (fire) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + $urandom_range(lat_lo, lat_hi));
    end
    if (redir) begin
      tgt = jalr_valid ? jalr_target : br_valid ? br_target : jal_valid ? jal_target : IRQV;
      if (take) m_epc = m_q[0].pc + 32'd4;
      m_q.delete();
      m_drop = owed;
      m_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      if (rsp) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          for (int i = 0; i < m_q.size(); i++) begin
            if (!m_q[i].filled) begin
              e = m_q[i]; e.filled = 1'b1; e.inst = imem_rsp_data; m_q[i] = e;
              break;
            end
          end
        end
      end
      if (dv && dec_ready) void'(m_q.pop_front());
      if (rv && imem_req_ready) begin
        e = '{pc: m_pc, inst: 32'h0, filled: 1'b0};
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_inputs();
    halt           = ($urandom_range(0, 7) == 0);
    dec_ready      = ($urandom_range(0, 3) != 0);
    imem_req_ready = ($urandom_range(0, 3) != 0);
    jalr_valid     = ($urandom_range(0, 24) == 0);
    br_valid       = ($urandom_range(0, 19) == 0);
    jal_valid      = ($urandom_range(0, 14) == 0);
    jalr_target    = $urandom;
    br_target      = $urandom;
    jal_target     = $urandom;
`ifdef FETCH_IRQ_EN
    irq            = ($urandom_range(0, 9) == 0);
`endif
  endtask

  task automatic clear_redirects();
    jalr_valid = 1'b0; br_valid = 1'b0; jal_valid = 1'b0;
`ifdef FETCH_IRQ_EN
    irq = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b0; halt = 1'b0; dec_ready = 1'b1; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    jalr_target = 32'h0; br_target = 32'h0; jal_target = 32'h0;
    clear_redirects();
    #2;
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_inst", dec_inst, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
`ifdef FETCH_IRQ_EN
    check("rst_epc", epc, 32'h0);
`endif
    @(posedge clock); #1;
    reset = 1'b1;

    // free run, latency 1
    steps(12);
    // decode stalled: queue fills to depth then issue stops
    dec_ready = 1'b0;
    steps(8);
    check("full_stall_req", {31'h0, imem_req_valid}, 32'h0);
    dec_ready = 1'b1;
    steps(3);
    // latency 3 then a misaligned branch target
    lat_lo = 3; lat_hi = 3;
    steps(6);
    br_valid = 1'b1; br_target = 32'h0000_0103;
    step();
    clear_redirects();
    check("br_addr", imem_req_addr, 32'h0000_0100);
    steps(10);
    // jalr outranks jal
    jalr_valid = 1'b1; jalr_target = 32'h0000_0200;
    jal_valid = 1'b1; jal_target = 32'h0000_0300;
    step();
    clear_redirects();
    check("jalr_prio_addr", imem_req_addr, 32'h0000_0200);
    steps(4);
    // halt mid-stream
    halt = 1'b1;
    steps(6);
    halt = 1'b0;
    steps(6);
`ifdef FETCH_IRQ_EN
    lat_lo = 1; lat_hi = 1;
    jal_valid = 1'b1; jal_target = 32'h0000_0040;
    step();
    clear_redirects();
    dec_ready = 1'b0;
    steps(8);
    check("irq_head_pc", dec_pc, 32'h0000_0040);
    irq = 1'b1; dec_ready = 1'b1;
    step();
    irq = 1'b0;
    check("irq_epc", epc, 32'h0000_0044);
    check("irq_addr", imem_req_addr, IRQV);
    steps(6);
`endif
    // random traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      step();
    end
    // reset mid-operation
    clear_redirects();
    imem_rsp_valid = 1'b0;
    reset = 1'b0;
    #2;
    check("mid_rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("mid_rst_dec_valid", {31'h0, dec_valid}, 32'h0);
    check("mid_rst_dec_pc", dec_pc, 32'h0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
